// File: rtl/riscv_pkg.sv
// Shared RV32M decode constants, operation/state enums and helpers for the
// execute-stage multiply/divide sequencer.
package riscv_pkg;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Values are the funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } md_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 datapath: unsigned shift-add multiply or restoring divide,
// one iteration per asserted step. Operands are magnitudes; hi:lo is product,
// or hi = remainder / lo = quotient after XLEN steps.
module muldiv_core
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            div_q;
  logic [XLEN:0]   add_sum;
  logic [XLEN+1:0] trial;
  logic            unused_trial;

  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  // Partial remainder shifted in with the next dividend bit, minus divisor; MSB is the borrow
  assign trial = {1'b0, hi_q, lo_q[XLEN-1]} - {2'b00, b_q};
  // Without a borrow the difference is below the divisor, so bit XLEN is always clear
  assign unused_trial = trial[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (!trial[XLEN+1]) begin
          hi_q <= trial[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {add_sum, lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M execute-stage sequencer: decode, FSM, sign handling, special cases, stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply for MUL/MULH*.
module ex_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic            inst_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);
  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_e       state, state_nx;
  muldiv_op_e      op_in, op_q;
  logic [CW-1:0]   cnt;
  logic            is_md, start, special, load, step, in_div;
  logic            s1, s2, neg_q, rsign_q, use_q;
  logic [XLEN-1:0] mag1, mag2, special_val, result_q, fin, core_hi, core_lo;
  logic            unused_bits;

  // Sign fix-up and word select shared by the iterative and single-cycle paths
  function automatic logic [XLEN-1:0] md_select(input muldiv_op_e op, input logic neg,
                                                input logic rsign, input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    p = neg ? -{hi, lo} : {hi, lo};
    case (op)
      OP_MUL:                       return p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              return neg ? -lo : lo;
      default:                      return rsign ? -hi : hi;
    endcase
  endfunction

  assign op_in       = muldiv_op_e'(inst[14:12]);
  assign in_div      = op_is_div(op_in);
  assign is_md       = inst_valid && (inst[6:0] == OPC_OP) && (inst[31:25] == F7_MULDIV);
  assign start       = is_md && !flush && (state == MD_IDLE);
  // Gated by rst_n so the hold releases the moment reset asserts
  assign stall       = rst_n && is_md && !flush && (state != MD_DONE);
  assign busy        = (state != MD_IDLE);
  assign unused_bits = ^{inst[24:15], inst[11:7]};

  assign s1   = rs1_data[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign s2   = rs2_data[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign mag1 = s1 ? -rs1_data : rs1_data;
  assign mag2 = s2 ? -rs2_data : rs2_data;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (in_div) begin
      if (rs2_data == '0) begin
        special     = 1'b1;
        special_val = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1_data;
      end else if ((op_in inside {OP_DIV, OP_REM}) && (rs2_data == '1) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}})) begin
        special     = 1'b1;
        special_val = (op_in == OP_DIV) ? rs1_data : '0;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      special     = 1'b1;
      special_val = md_select(op_in, s1 ^ s2, s1, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
    end
`endif
  end

  always_comb begin
    state_nx = state;
    load     = start;
    step     = 1'b0;
    case (state)
      MD_IDLE: if (start) state_nx = special ? MD_DONE : MD_CALC;
      MD_CALC: begin
        step = 1'b1;
        if (cnt == LAST) state_nx = MD_DONE;
      end
      MD_DONE: state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
    if (flush) state_nx = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rsign_q  <= 1'b0;
      use_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        cnt     <= '0;
        op_q    <= op_in;
        neg_q   <= s1 ^ s2;
        rsign_q <= s1;
        use_q   <= special;
        if (special) result_q <= special_val;
      end else if (state == MD_CALC) begin
        cnt <= cnt + 1'b1;
      end
      if (result_valid) result_q <= result;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (in_div),
    .a      (mag1),
    .b      (mag2),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign result_valid = (state == MD_DONE) && !flush;
  assign fin          = md_select(op_q, neg_q, rsign_q, core_hi, core_lo);
  assign result       = (result_valid && !use_q) ? fin : result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq (default or MULDIV_FAST_MUL_EN build).
module tb_ex_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        flush;
  logic [31:0] rs1_data, rs2_data;
  logic        stall, result_valid, busy;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [31:0] ADD_INST = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

  ex_muldiv_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .flush        (flush),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] md_inst(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; issues one M op, counts stall cycles, returns at posedge+1 after the op
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc = 0;
    int stalls = 0;
    bit seen = 0;
    inst = md_inst(f3); inst_valid = 1'b1; rs1_data = a; rs2_data = b;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (stall) stalls++;
      if (result_valid) begin
        seen = 1;
        check({tag, "_res"}, result, exp_res);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      end
      @(posedge clk); #1;
      if (!seen) cyc++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
    inst_valid = 1'b0; inst = ADD_INST;
    @(negedge clk);
    check({tag, "_hold"}, result, exp_res);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; inst = ADD_INST; inst_valid = 1'b0; flush = 1'b0;
    rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_md("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_md("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
    run_md("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_md("div0",   3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
    run_md("remu0",  3'd7, 32'd7,        32'd0,        32'd7,        1);
    run_md("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_md("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    run_md("remu",   3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_md("div",    3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, DIV_LAT);

    // DIVU flushed at cycle 10: no result, then a clean DIV
    inst = md_inst(3'd5); inst_valid = 1'b1; rs1_data = 32'd100; rs2_data = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush_pre_valid", {31'd0, result_valid}, 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; inst_valid = 1'b0; inst = ADD_INST;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("flush_post_valid", {31'd0, result_valid}, 32'd0);
    end
    @(posedge clk); #1;
    run_md("div_after_flush", 3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT);

    // Non-M instruction never stalls
    inst = ADD_INST; inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("add_stall", {31'd0, stall}, 32'd0);
      check("add_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a MUL
    inst = md_inst(3'd0); inst_valid = 1'b1; rs1_data = 32'd7; rs2_data = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    inst = ADD_INST;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_add_stall", {31'd0, stall}, 32'd0);
      check("post_rst_add_valid", {31'd0, result_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
